// File: rtl/load_module.sv
// ---------------------------------------------------------------------------
// load_module: cache-to-core read path with SEC-DED checking.
//   Stage S1 captures the cache word and its 7-bit check field. The syndrome
//   is computed from the S1 registers. Stage S2 holds the corrected word for
//   the core behind a valid/ready handshake. Every corrected word is counted
//   and, when the scrub FSM is idle, queued as a scrub write-back.
//
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   data_Cache/parity_Cache     word and check field offered by the cache
//   special_load_Cache          side flag carried with the word
//   valid_Cache / ready_Cache   cache-side handshake
//   data_PC, special_load_PC,
//   err_sec_PC, err_ded_PC      registered S2 payload to the core
//   valid_PC / ready_PC         core-side handshake
//   scrub_req/data/parity/ack   scrub write-back request and payload
//   count_clr                   synchronous clear of both event counters
//   sec_count, ded_count        saturating event counters
// ---------------------------------------------------------------------------

package load_module_pkg;

    // Hamming position (1..38) of data bit idx; check bits occupy powers of two.
    function automatic logic [5:0] data_pos(input int idx);
        int cnt;
        data_pos = '0;
        cnt      = 0;
        for (int q = 1; q <= 38; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (cnt == idx) begin
                    data_pos = 6'(q);
                end
                cnt++;
            end
        end
    endfunction

endpackage

// Parity_Encoder: [5:0] Hamming check bits, [6] even parity over data and checks.
module Parity_Encoder (
    input  logic [31:0] i_data,
    output logic [6:0]  o_parity
);
    import load_module_pkg::*;

    logic [5:0] w_chk;
    logic [5:0] w_pos;

    // Each check bit covers the data bits whose position has that bit set.
    always_comb begin
        w_chk = '0;
        w_pos = '0;
        for (int i = 0; i < 32; i++) begin
            w_pos = data_pos(i);
            for (int k = 0; k < 6; k++) begin
                if (w_pos[k]) begin
                    w_chk[k] = w_chk[k] ^ i_data[i];
                end
            end
        end
    end

    assign o_parity = {^{i_data, w_chk}, w_chk};

endmodule

module load_module #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        data_Cache,
    input  logic [6:0]         parity_Cache,
    input  logic               special_load_Cache,
    input  logic               valid_Cache,
    output logic               ready_Cache,
    output logic [31:0]        data_PC,
    output logic               special_load_PC,
    output logic               err_sec_PC,
    output logic               err_ded_PC,
    output logic               valid_PC,
    input  logic               ready_PC,
    output logic               scrub_req,
    output logic [31:0]        scrub_data,
    output logic [6:0]         scrub_parity,
    input  logic               scrub_ack,
    input  logic               count_clr,
    output logic [COUNT_W-1:0] sec_count,
    output logic [COUNT_W-1:0] ded_count
);
    import load_module_pkg::*;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } scrub_state_t;

    scrub_state_t r_state;

    logic        r_s1_valid;
    logic [31:0] r_s1_data;
    logic [6:0]  r_s1_parity;
    logic        r_s1_special;

    logic [6:0]  w_enc_s1;
    logic [6:0]  w_scrub_par;
    logic [5:0]  w_syn;
    logic        w_ovl;
    logic        w_sec;
    logic        w_ded;
    logic [31:0] w_corr;
    logic        w_s2_adv;
    logic        w_s2_load;

    // Handshake: S2 advances when empty or drained; S1 refills when it moves on.
    assign w_s2_adv    = !valid_PC || ready_PC;
    assign ready_Cache = !r_s1_valid || w_s2_adv;
    assign w_s2_load   = w_s2_adv && r_s1_valid;

    Parity_Encoder u_syn_enc (
        .i_data   (r_s1_data),
        .o_parity (w_enc_s1)
    );

    Parity_Encoder u_scrub_enc (
        .i_data   (w_corr),
        .o_parity (w_scrub_par)
    );

    // Since enc[6] = ^data ^ ^enc[5:0], the overall parity of the received
    // word reduces to enc[6] ^ ^syn ^ parity[6].
    assign w_syn = w_enc_s1[5:0] ^ r_s1_parity[5:0];
    assign w_ovl = w_enc_s1[6] ^ (^w_syn) ^ r_s1_parity[6];

    // Classify and correct; syn==0 or a check position leaves data untouched.
    always_comb begin
        w_sec  = 1'b0;
        w_ded  = 1'b0;
        w_corr = r_s1_data;
        if (w_ovl) begin
            if (w_syn <= 6'd38) begin
                w_sec = 1'b1;
                for (int i = 0; i < 32; i++) begin
                    if (w_syn == data_pos(i)) begin
                        w_corr[i] = ~r_s1_data[i];
                    end
                end
            end else begin
                w_ded = 1'b1;
            end
        end else if (w_syn != 6'd0) begin
            w_ded = 1'b1;
        end
    end

    // S1 capture register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_parity  <= '0;
            r_s1_special <= 1'b0;
        end else if (ready_Cache) begin
            r_s1_valid <= valid_Cache;
            if (valid_Cache) begin
                r_s1_data    <= data_Cache;
                r_s1_parity  <= parity_Cache;
                r_s1_special <= special_load_Cache;
            end
        end
    end

    // S2 output register; holds while the core stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_PC        <= 1'b0;
            data_PC         <= '0;
            special_load_PC <= 1'b0;
            err_sec_PC      <= 1'b0;
            err_ded_PC      <= 1'b0;
        end else if (w_s2_adv) begin
            valid_PC <= r_s1_valid;
            if (r_s1_valid) begin
                data_PC         <= w_corr;
                special_load_PC <= r_s1_special;
                err_sec_PC      <= w_sec;
                err_ded_PC      <= w_ded;
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (count_clr) begin
            sec_count <= '0;
            ded_count <= '0;
        end else begin
            if (w_s2_load && w_sec && (sec_count != '1)) begin
                sec_count <= sec_count + COUNT_W'(1);
            end
            if (w_s2_load && w_ded && (ded_count != '1)) begin
                ded_count <= ded_count + COUNT_W'(1);
            end
        end
    end

    // Scrub FSM: one outstanding request; SEC words arriving meanwhile are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            scrub_req    <= 1'b0;
            scrub_data   <= '0;
            scrub_parity <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_s2_load && w_sec) begin
                        r_state      <= S_REQ;
                        scrub_req    <= 1'b1;
                        scrub_data   <= w_corr;
                        scrub_parity <= w_scrub_par;
                    end
                end
                S_REQ: begin
                    if (scrub_ack) begin
                        r_state   <= S_IDLE;
                        scrub_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    scrub_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
